// File: rtl/sc_reg_shifter_seq_pkg.sv
// Shared encodings for the sequential load/shift register.
// Holds the command and FSM state encodings.
package sc_regshifterseq_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_SHR  = 2'b10,
    CMD_SHL  = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sc_reg_shifter_seq_if.sv
// Command/data bundle of the sequential load/shift register.
// The master drives commands; the slave (the register) returns contents and status.
interface sc_reg_shifter_seq_if #(
  parameter int DATAWIDTH  = 8,
  parameter int SHAMTWIDTH = 4
);
  logic                  SC_RegSHIFTERSEQ_start_InLow;
  logic [1:0]            SC_RegSHIFTERSEQ_cmd_InBUS;
  logic [SHAMTWIDTH-1:0] SC_RegSHIFTERSEQ_shamt_InBUS;
  logic                  SC_RegSHIFTERSEQ_serial_In;
  logic [DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_InBUS;
  logic [DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_OutBUS;
  logic                  SC_RegSHIFTERSEQ_busy_Out;
  logic                  SC_RegSHIFTERSEQ_done_Out;
  logic                  SC_RegSHIFTERSEQ_zero_Out;
  logic                  SC_RegSHIFTERSEQ_lsb_Out;
  logic                  SC_RegSHIFTERSEQ_ovf_Out;

  modport master (
    output SC_RegSHIFTERSEQ_start_InLow, SC_RegSHIFTERSEQ_cmd_InBUS,
           SC_RegSHIFTERSEQ_shamt_InBUS, SC_RegSHIFTERSEQ_serial_In,
           SC_RegSHIFTERSEQ_data_InBUS,
    input  SC_RegSHIFTERSEQ_data_OutBUS, SC_RegSHIFTERSEQ_busy_Out,
           SC_RegSHIFTERSEQ_done_Out, SC_RegSHIFTERSEQ_zero_Out,
           SC_RegSHIFTERSEQ_lsb_Out, SC_RegSHIFTERSEQ_ovf_Out
  );

  modport slave (
    input  SC_RegSHIFTERSEQ_start_InLow, SC_RegSHIFTERSEQ_cmd_InBUS,
           SC_RegSHIFTERSEQ_shamt_InBUS, SC_RegSHIFTERSEQ_serial_In,
           SC_RegSHIFTERSEQ_data_InBUS,
    output SC_RegSHIFTERSEQ_data_OutBUS, SC_RegSHIFTERSEQ_busy_Out,
           SC_RegSHIFTERSEQ_done_Out, SC_RegSHIFTERSEQ_zero_Out,
           SC_RegSHIFTERSEQ_lsb_Out, SC_RegSHIFTERSEQ_ovf_Out
  );
endinterface

// File: rtl/sc_reg_shifter_seq_counter.sv
// Loadable down-counter tracking the remaining shift steps.
// last is high while exactly one step remains.
module sc_shift_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);
  logic [WIDTH-1:0] count;

  // Load on command accept, otherwise count down once per shift step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == WIDTH'(1));
endmodule

// File: rtl/sc_reg_shifter_seq.sv
// Sequential load / multi-bit shift register with start/done handshake.
// Optional sticky left-shift overflow flag enabled by `define SC_REGSHIFTERSEQ_OVF_EN.
module sc_reg_shifter_seq
  import sc_regshifterseq_pkg::*;
#(
  parameter int RegSHIFTERSEQ_DATAWIDTH  = 8,
  parameter int RegSHIFTERSEQ_SHAMTWIDTH = 4
) (
  input  logic                 SC_RegSHIFTERSEQ_CLOCK_50,
  input  logic                 SC_RegSHIFTERSEQ_RESET_InHigh,
  sc_reg_shifter_seq_if.slave  bus
);
  localparam int W = RegSHIFTERSEQ_DATAWIDTH;

  logic   clk;
  logic   rst;
  state_t state;
  cmd_t   cmd;
  logic [W-1:0] data_q;
  logic   busy_q;
  logic   done_q;
  logic   shift_left;
  logic   accept;
  logic   shamt_zero;
  logic   ctr_load;
  logic   ctr_last;

  assign clk        = SC_RegSHIFTERSEQ_CLOCK_50;
  assign rst        = SC_RegSHIFTERSEQ_RESET_InHigh;
  assign cmd        = cmd_t'(bus.SC_RegSHIFTERSEQ_cmd_InBUS);
  assign accept     = (state == ST_IDLE) && !bus.SC_RegSHIFTERSEQ_start_InLow;
  assign shamt_zero = (bus.SC_RegSHIFTERSEQ_shamt_InBUS == '0);
  assign ctr_load   = accept && ((cmd == CMD_SHR) || (cmd == CMD_SHL)) && !shamt_zero;

  sc_shift_counter #(
    .WIDTH(RegSHIFTERSEQ_SHAMTWIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .dec      (state == ST_SHIFT),
    .load_val (bus.SC_RegSHIFTERSEQ_shamt_InBUS),
    .last     (ctr_last)
  );

`ifdef SC_REGSHIFTERSEQ_OVF_EN
  logic ovf_q;
`endif

  // Control FSM and datapath register; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every flop here has an explicit reset; the register is a single word, not a memory array.
      state      <= ST_IDLE;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_left <= 1'b0;
`ifdef SC_REGSHIFTERSEQ_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (accept) begin
            case (cmd)
              CMD_LOAD: begin
                data_q <= bus.SC_RegSHIFTERSEQ_data_InBUS;
                state  <= ST_DONE;
                busy_q <= 1'b1;
                done_q <= 1'b1;
`ifdef SC_REGSHIFTERSEQ_OVF_EN
                ovf_q  <= 1'b0;
`endif
              end
              CMD_SHR, CMD_SHL: begin
                shift_left <= (cmd == CMD_SHL);
                busy_q     <= 1'b1;
                if (shamt_zero) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= ST_SHIFT;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          if (shift_left) begin
            data_q <= {data_q[W-2:0], bus.SC_RegSHIFTERSEQ_serial_In};
`ifdef SC_REGSHIFTERSEQ_OVF_EN
            if (data_q[W-1]) ovf_q <= 1'b1;
`endif
          end else begin
            data_q <= {bus.SC_RegSHIFTERSEQ_serial_In, data_q[W-1:1]};
          end
          if (ctr_last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_RegSHIFTERSEQ_data_OutBUS = data_q;
  assign bus.SC_RegSHIFTERSEQ_busy_Out    = busy_q;
  assign bus.SC_RegSHIFTERSEQ_done_Out    = done_q;
  assign bus.SC_RegSHIFTERSEQ_zero_Out    = (data_q == '0);
  assign bus.SC_RegSHIFTERSEQ_lsb_Out     = data_q[0];
`ifdef SC_REGSHIFTERSEQ_OVF_EN
  assign bus.SC_RegSHIFTERSEQ_ovf_Out     = ovf_q;
`else
  assign bus.SC_RegSHIFTERSEQ_ovf_Out     = 1'b0;
`endif
endmodule

// File: tb/tb_sc_reg_shifter_seq.sv
// Scoreboard bench for sc_reg_shifter_seq (DATAWIDTH=8, SHAMTWIDTH=4).
// Expected overflow behaviour follows `define SC_REGSHIFTERSEQ_OVF_EN.
module tb_sc_reg_shifter_seq;
  import sc_regshifterseq_pkg::*;

`ifdef SC_REGSHIFTERSEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] val;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [3:0] shamt = 4'd0;
  logic       serial = 1'b0;
  logic [7:0] din = 8'h00;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference state: register value and sticky overflow.
  logic [7:0] m_val = 8'h00;
  logic       m_ovf = 1'b0;

  sc_reg_shifter_seq_if #(.DATAWIDTH(8), .SHAMTWIDTH(4)) bus ();

  assign bus.SC_RegSHIFTERSEQ_start_InLow = start_n;
  assign bus.SC_RegSHIFTERSEQ_cmd_InBUS   = cmd;
  assign bus.SC_RegSHIFTERSEQ_shamt_InBUS = shamt;
  assign bus.SC_RegSHIFTERSEQ_serial_In   = serial;
  assign bus.SC_RegSHIFTERSEQ_data_InBUS  = din;

  wire [7:0] dout   = bus.SC_RegSHIFTERSEQ_data_OutBUS;
  wire       busy   = bus.SC_RegSHIFTERSEQ_busy_Out;
  wire       done   = bus.SC_RegSHIFTERSEQ_done_Out;
  wire       zero   = bus.SC_RegSHIFTERSEQ_zero_Out;
  wire       lsb    = bus.SC_RegSHIFTERSEQ_lsb_Out;
  wire       ovf    = bus.SC_RegSHIFTERSEQ_ovf_Out;

  sc_reg_shifter_seq #(
    .RegSHIFTERSEQ_DATAWIDTH (8),
    .RegSHIFTERSEQ_SHAMTWIDTH(4)
  ) dut (
    .SC_RegSHIFTERSEQ_CLOCK_50    (clk),
    .SC_RegSHIFTERSEQ_RESET_InHigh(rst),
    .bus                          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending command at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_data", dout, e.val);
        check("done_ovf", ovf, e.ovf);
        check("done_zero", zero, e.val == 8'h00);
        check("done_lsb", lsb, e.val[0]);
        check("done_busy", busy, 1'b1);
      end
    end
  end

  // Issue one command starting at the current falling edge and follow it to idle.
  // fill: 0/1 fixed serial value, 2 random per step. inject: start a LOAD mid-shift.
  task automatic run_cmd(input logic [1:0] c, input logic [3:0] k, input logic [7:0] d,
                         input int fill, input bit inject);
    logic       s [16];
    logic [7:0] step_val [16];
    int         steps;
    exp_t       e;
    start_n = 1'b0;
    cmd     = c;
    shamt   = k;
    din     = d;
    steps   = (c == CMD_SHR || c == CMD_SHL) ? int'(k) : 0;
    if (c == CMD_NOP) begin
      @(negedge clk);
      start_n = 1'b1;
      check("nop_busy", busy, 1'b0);
      check("nop_done", done, 1'b0);
      return;
    end
    if (c == CMD_LOAD) begin
      m_val = d;
      m_ovf = 1'b0;
    end
    for (int i = 0; i < steps; i++) begin
      s[i] = (fill == 2) ? 1'($urandom_range(0, 1)) : (fill == 1);
      if (c == CMD_SHR) begin
        m_val = (m_val >> 1) | (8'(s[i]) << 7);
      end else begin
        if (m_val >= 8'h80) m_ovf = m_ovf | OVF_EN;
        m_val = 8'((m_val << 1) | 8'(s[i]));
      end
      step_val[i] = m_val;
    end
    e.val = m_val;
    e.ovf = m_ovf;
    sb.push_back(e);
    @(negedge clk);
    start_n = 1'b1;
    if (steps == 0) begin
      check("cmd_done_e0", done, 1'b1);
    end else begin
      check("shift_busy", busy, 1'b1);
      check("shift_nodone", done, 1'b0);
    end
    for (int i = 0; i < steps; i++) begin
      serial = s[i];
      if (inject && i == 1) begin
        start_n = 1'b0;
        cmd     = CMD_LOAD;
        din     = 8'hFF;
      end
      @(negedge clk);
      start_n = 1'b1;
      check("step_data", dout, step_val[i]);
      check("step_done", done, i == steps - 1);
    end
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_data", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_zero", zero, 1'b1);
    check("rst_lsb", lsb, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    run_cmd(CMD_LOAD, 4'd0, 8'h1B, 0, 1'b0);
    run_cmd(CMD_LOAD, 4'd0, 8'hB4, 0, 1'b0);
    run_cmd(CMD_SHR, 4'd3, 8'h00, 0, 1'b0);
    check("shr3_result", dout, 8'h16);
    run_cmd(CMD_LOAD, 4'd0, 8'h81, 0, 1'b0);
    run_cmd(CMD_SHL, 4'd2, 8'h00, 1, 1'b0);
    check("shl2_result", dout, 8'h07);
    check("shl2_ovf", ovf, OVF_EN);
    run_cmd(CMD_LOAD, 4'd0, 8'h55, 0, 1'b0);
    check("load_clears_ovf", ovf, 1'b0);
    run_cmd(CMD_SHR, 4'd5, 8'h00, 2, 1'b1);

    // Reset lands on the second step of a 4-bit left shift.
    run_cmd(CMD_LOAD, 4'd0, 8'h81, 0, 1'b0);
    start_n = 1'b0;
    cmd     = CMD_SHL;
    shamt   = 4'd4;
    @(negedge clk);
    start_n = 1'b1;
    serial  = 1'b1;
    @(negedge clk);
    check("pre_rst_step", dout, 8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_val = 8'h00;
    m_ovf = 1'b0;
    check("midrst_data", dout, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    @(negedge clk);
    check("midrst_nodone", done, 1'b0);
    run_cmd(CMD_LOAD, 4'd0, 8'h66, 0, 1'b0);

    run_cmd(CMD_LOAD, 4'd0, 8'h3C, 0, 1'b0);
    run_cmd(CMD_SHR, 4'd0, 8'h00, 0, 1'b0);
    run_cmd(CMD_NOP, 4'd0, 8'hAA, 0, 1'b0);
    check("nop_keeps", dout, 8'h3C);

    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 2, 1'b0);
    end
    check("final_data", dout, m_val);
    check("final_ovf", ovf, m_ovf);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
